// File: rtl/instr_loader_pkg.sv
// Shared types for the boot image loader: FSM state encoding and word geometry.
package instr_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    WORD,
    WRITE,
    DONE,
    ERROR
  } state_e;

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Little-endian byte-to-word shift register; full_o flags the byte that completes a word.
// Zero latency on full_o; no backpressure of its own, the caller only strobes take_i on accepted bytes.
module word_assembler
  import instr_loader_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               take_i,
  input  logic [7:0]         byte_data_i,
  output logic [width_p-1:0] word_o,
  output logic               full_o
);

  logic [width_p-1:0] word_q;
  logic [LANE_W-1:0]  idx_q;

  assign full_o = take_i && (idx_q == LANE_W'(BYTES_PER_WORD - 1));
  assign word_o = word_q;

  // Shifting in from the top leaves the first byte received in bits 7:0.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (clear_i) begin
      idx_q  <= '0;
    end else if (take_i) begin
      word_q <= {byte_data_i, word_q[width_p-1:8]};
      idx_q  <= full_o ? '0 : idx_q + LANE_W'(1);
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Streams a length-prefixed byte image into instruction memory, holding the core in reset until done.
// Writes one cycle after a word's 4th byte; byte_ready_o drops during writes and in DONE/ERROR.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int width_p = 32,
  parameter int depth_p = 1024
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         byte_valid_i,
  input  logic [7:0]                   byte_data_i,
  output logic                         byte_ready_o,
  output logic                         load_enable_o,
  output logic [$clog2(depth_p*4)-1:0] load_addr_o,
  output logic [width_p-1:0]           load_data_o,
  input  logic                         restart_i,
  output logic                         done_o,
  output logic                         error_o,
  output logic                         core_reset_o
);

  localparam int addr_w_lp = $clog2(depth_p * 4);
  localparam logic [addr_w_lp-1:0] last_addr_lp = addr_w_lp'((depth_p - 1) * BYTES_PER_WORD);
  localparam logic [addr_w_lp-1:0] step_lp      = addr_w_lp'(BYTES_PER_WORD);

  state_e               state_q, state_d;
  logic                 armed_q;
  logic [7:0]           n_lo_q;
  logic [15:0]          n_q, n_in, cnt_q, cnt_inc;
  logic [addr_w_lp-1:0] addr_q;
  logic                 take, word_full, latch_lo, latch_n, advance, clear;
  logic [width_p-1:0]   word;

  // armed_q keeps ready low until the first edge after reset release.
  assign byte_ready_o = armed_q && (state_q inside {LEN_LO, LEN_HI, WORD});
  assign take         = byte_valid_i && byte_ready_o;
  assign n_in         = {byte_data_i, n_lo_q};
  assign cnt_inc      = cnt_q + 16'd1;

  word_assembler #(.width_p(width_p)) u_word_assembler (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .clear_i     (clear),
    .take_i      (take && (state_q == WORD)),
    .byte_data_i (byte_data_i),
    .word_o      (word),
    .full_o      (word_full)
  );

  always_comb begin
    state_d       = state_q;
    load_enable_o = 1'b0;
    latch_lo      = 1'b0;
    latch_n       = 1'b0;
    advance       = 1'b0;
    clear         = 1'b0;
    case (state_q)
      LEN_LO: if (take) begin
        latch_lo = 1'b1;
        state_d  = LEN_HI;
      end
      LEN_HI: if (take) begin
        latch_n = 1'b1;
        if (n_in == 16'd0)                      state_d = DONE;
        else if ({16'd0, n_in} > 32'(depth_p))  state_d = ERROR;
        else                                    state_d = WORD;
      end
      WORD: if (word_full) state_d = WRITE;
      WRITE: begin
        load_enable_o = 1'b1;
        advance       = 1'b1;
        state_d       = (cnt_inc == n_q) ? DONE : WORD;
      end
      DONE, ERROR: if (restart_i) begin
        clear   = 1'b1;
        state_d = LEN_LO;
      end
      default: state_d = LEN_LO;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= LEN_LO;
      armed_q <= 1'b0;
      n_lo_q  <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      if (latch_lo) n_lo_q <= byte_data_i;
      if (latch_n)  n_q    <= n_in;
      if (clear) begin
        cnt_q  <= '0;
        addr_q <= '0;
      end else if (advance) begin
        cnt_q  <= cnt_inc;
        // A full-depth image wraps back to 0 after its last write.
        addr_q <= (addr_q == last_addr_lp) ? '0 : addr_q + step_lp;
      end
    end
  end

  assign load_addr_o  = addr_q;
  assign load_data_o  = load_enable_o ? word : '0;
  assign done_o       = (state_q == DONE);
  assign error_o      = (state_q == ERROR);
  assign core_reset_o = (state_q != DONE);

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: a byte-count model predicts outputs every cycle, plus literal image checks.
module tb_instr_loader;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0, restart = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        byte_ready_o, load_enable_o, done_o, error_o, core_reset_o;
  logic [11:0] load_addr_o;
  logic [31:0] load_data_o;

  instr_loader #(.width_p(32), .depth_p(DEPTH)) dut (
    .clk_i         (clk),
    .reset_i       (rst_n),
    .byte_valid_i  (valid),
    .byte_data_i   (data),
    .byte_ready_o  (byte_ready_o),
    .load_enable_o (load_enable_o),
    .load_addr_o   (load_addr_o),
    .load_data_o   (load_data_o),
    .restart_i     (restart),
    .done_o        (done_o),
    .error_o       (error_o),
    .core_reset_o  (core_reset_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks bytes accepted in the current image and derives everything from that count.
  logic [7:0]  img[$];
  int          m_k, m_n, m_words;
  bit          m_armed, m_done, m_err, m_wr;
  logic [31:0] m_data;
  logic [11:0] m_addr;

  function automatic bit exp_rdy();
    return m_armed && !m_done && !m_err && !m_wr;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img.delete();
      m_k = 0; m_n = 0; m_words = 0;
      m_armed = 0; m_done = 0; m_err = 0; m_wr = 0;
    end else begin
      if (restart && (m_done || m_err)) begin
        img.delete();
        m_k = 0; m_words = 0; m_done = 0; m_err = 0;
      end else if (m_wr) begin
        m_wr = 0;
        m_words++;
        if (m_words == m_n) m_done = 1;
      end else if (valid && exp_rdy()) begin
        img.push_back(data);
        m_k++;
        if (m_k == 2) begin
          m_n = {img[1], img[0]};
          if (m_n == 0) m_done = 1;
          else if (m_n > DEPTH) m_err = 1;
        end else if (m_k > 2 && (m_k - 2) % 4 == 0) begin
          m_wr   = 1;
          m_data = {img[m_k-1], img[m_k-2], img[m_k-3], img[m_k-4]};
          m_addr = 12'((m_words * 4) % (DEPTH * 4));
        end
      end
      m_armed = 1;
    end
  end

  typedef struct { logic [11:0] a; logic [31:0] d; } wr_t;
  wr_t log_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", byte_ready_o, 0);
      chk("rst_load_en", load_enable_o, 0);
      chk("rst_load_data", load_data_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_error", error_o, 0);
      chk("rst_core_reset", core_reset_o, 1);
    end else begin
      chk("ready", byte_ready_o, exp_rdy());
      chk("load_en", load_enable_o, m_wr);
      chk("done", done_o, m_done);
      chk("error", error_o, m_err);
      chk("core_reset", core_reset_o, !m_done);
      chk("addr_align", load_addr_o[1:0], 0);
      if (m_wr) begin
        chk("wr_addr", load_addr_o, m_addr);
        chk("wr_data", load_data_o, m_data);
      end
      if (load_enable_o) log_q.push_back('{a: load_addr_o, d: load_data_o});
    end
  end

  logic [7:0] stim[$];

  task automatic send_byte(input logic [7:0] b, input int pct, input bit noise);
    int guard = 0;
    bit acc;
    data = b;
    forever begin
      valid   = ($urandom_range(99) < pct);
      restart = noise && ($urandom_range(3) == 0);
      @(negedge clk);
      acc = valid && byte_ready_o;
      @(posedge clk);
      #1;
      if (acc) break;
      guard++;
      if (guard > 400) begin
        n_vec++;
        n_fail++;
        $display("FAIL accept_timeout: byte 0x%0h not accepted, ready=%0b", b, byte_ready_o);
        break;
      end
    end
    valid   = 1'b0;
    restart = 1'b0;
  endtask

  task automatic send_stim(input int pct, input bit noise);
    foreach (stim[i]) send_byte(stim[i], pct, noise);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    idle(1);
    restart = 1'b0;
  endtask

  task automatic build_image(input int n);
    stim.delete();
    stim.push_back(n[7:0]);
    stim.push_back(n[15:8]);
    repeat (4 * n) stim.push_back(8'($urandom));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    rst_n = 1'b1;
    chk("ready_before_edge", byte_ready_o, 0);
    idle(1);
    chk("ready_after_release", byte_ready_o, 1);

    // Two-word image.
    log_q.delete();
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_stim(100, 0);
    idle(4);
    chk("two_word_count", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      chk("two_word_a0", log_q[0].a, 12'h000);
      chk("two_word_d0", log_q[0].d, 32'h0000_0013);
      chk("two_word_a1", log_q[1].a, 12'h004);
      chk("two_word_d1", log_q[1].d, 32'h0010_0093);
    end
    chk("two_word_done", done_o, 1);
    chk("two_word_core_reset", core_reset_o, 0);

    // Restart from DONE and load a single word with stalls.
    do_restart();
    chk("restart_clears_done", done_o, 0);
    log_q.delete();
    stim = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_stim(60, 0);
    idle(4);
    chk("beef_count", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      chk("beef_addr", log_q[0].a, 12'h000);
      chk("beef_data", log_q[0].d, 32'hDEAD_BEEF);
    end
    chk("beef_done", done_o, 1);

    // Empty image.
    do_restart();
    log_q.delete();
    stim = '{8'h00, 8'h00};
    send_stim(100, 0);
    chk("empty_done", done_o, 1);
    idle(3);
    chk("empty_no_writes", log_q.size(), 0);

    // Count one above depth; bytes offered afterwards must be ignored.
    do_restart();
    log_q.delete();
    stim = '{8'h01, 8'h04};
    send_stim(100, 0);
    idle(2);
    chk("over_error", error_o, 1);
    chk("over_ready", byte_ready_o, 0);
    valid = 1'b1;
    data  = 8'h5A;
    idle(6);
    valid = 1'b0;
    chk("over_no_writes", log_q.size(), 0);
    do_restart();
    chk("over_restart_clears", error_o, 0);

    // One word, random valid, restart noise while loading.
    log_q.delete();
    build_image(1);
    send_stim(35, 1);
    idle(3);
    chk("one_word_count", log_q.size(), 1);
    if (log_q.size() >= 1)
      chk("one_word_data", log_q[0].d, {stim[5], stim[4], stim[3], stim[2]});
    chk("one_word_done", done_o, 1);

    // Reset mid-image, then a fresh image loads from address 0.
    do_restart();
    build_image(3);
    for (int i = 0; i < 6; i++) send_byte(stim[i], 100, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_core_reset", core_reset_o, 1);
    chk("midrst_ready", byte_ready_o, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    log_q.delete();
    build_image(2);
    send_stim(80, 0);
    idle(3);
    chk("midrst_count", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      chk("midrst_a0", log_q[0].a, 12'h000);
      chk("midrst_a1", log_q[1].a, 12'h004);
    end

    // Random images.
    for (int t = 0; t < 12; t++) begin
      do_restart();
      log_q.delete();
      build_image($urandom_range(1, 6));
      send_stim($urandom_range(30, 100), 1);
      idle(3);
      chk("rand_done", done_o, 1);
      chk("rand_count", log_q.size(), (stim.size() - 2) / 4);
    end

    // Full-depth image.
    do_restart();
    log_q.delete();
    build_image(DEPTH);
    send_stim(100, 0);
    idle(3);
    chk("full_count", log_q.size(), DEPTH);
    if (log_q.size() == DEPTH)
      chk("full_last_addr", log_q[DEPTH-1].a, 12'hFFC);
    chk("full_done", done_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
